// File: rtl/llc_rst_flush_seq.sv
// LLC reset/flush sequencer.
// Walks every LLC set. The reset sweep invalidates whole sets. The flush sweep
// reads each set, evicts the selected lines one by one over a valid/ready
// handshake, and invalidates each line once its evict has been accepted.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | no sweep running
// RST_WALK    | invalidate all ways of walk_set, one set per cycle
// FL_RD       | issue the tag/state read for walk_set
// FL_LOOKUP   | read data valid: capture tags, build the pending mask
// FL_SCAN     | pick the lowest pending way, or move on when none is left
// FL_EVICT    | evict request held until memory accepts it
// FL_INV      | invalidate the evicted way and drop it from the mask
// FL_NEXT     | advance to the next set, or finish after the last set
module llc_rst_flush_seq #(
    parameter int SET_BITS = 8,
    parameter int WAYS     = 16,
    parameter int WAY_BITS = 4,
    parameter int TAG_BITS = 14
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_rst,
    input  logic                         start_flush,
    input  logic                         flush_all,
    output logic                         rd_set_en,
    output logic [SET_BITS-1:0]          walk_set,
    input  logic [2*WAYS-1:0]            states_buf,
    input  logic [WAYS*TAG_BITS-1:0]     tags_buf,
    output logic                         evict_valid,
    input  logic                         evict_ready,
    output logic [TAG_BITS+SET_BITS-1:0] evict_addr,
    output logic [WAY_BITS-1:0]          evict_way,
    output logic                         wr_inv_way,
    output logic                         wr_inv_set,
    output logic                         rst_stall,
    output logic                         flush_stall,
    output logic                         done
);

    typedef enum logic [2:0] {
        S_IDLE, S_RST_WALK, S_FL_RD, S_FL_LOOKUP,
        S_FL_SCAN, S_FL_EVICT, S_FL_INV, S_FL_NEXT
    } state_t;

    localparam logic [SET_BITS-1:0] SET_ONE  = SET_BITS'(1);
    localparam logic [SET_BITS-1:0] SET_LAST = '1;

    state_t                         r_state;
    logic [SET_BITS-1:0]            r_walk_set;
    logic                           r_done;
    logic                           r_fl_all;
    logic                           r_rst_pend;
    logic                           r_go;
    logic [WAYS-1:0]                r_mask;
    logic [WAYS*TAG_BITS-1:0]       r_tags;
    logic [WAY_BITS-1:0]            r_evict_way;
    logic [TAG_BITS+SET_BITS-1:0]   r_evict_addr;

    state_t                         w_state_nxt;
    logic [SET_BITS-1:0]            w_walk_nxt;
    logic                           w_done_nxt;
    logic                           w_rst_pend_nxt;
    logic                           w_capture;
    logic                           w_load_evict;
    logic                           w_clr_bit;
    logic                           w_latch_fl;
    logic [WAYS-1:0]                w_pend;
    logic [WAY_BITS-1:0]            w_sel_way;
    logic                           w_sel_hit;
    logic [TAG_BITS-1:0]            w_sel_tag;

    // Lines to evict: valid and either dirty or the sweep evicts every valid line.
    always_comb begin
        w_pend = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_pend[w] = states_buf[2*w+1] & (states_buf[2*w] | r_fl_all);
        end
    end

    // Lowest pending way wins.
    always_comb begin
        w_sel_way = '0;
        w_sel_hit = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_mask[w]) begin
                w_sel_way = WAY_BITS'(w);
                w_sel_hit = 1'b1;
            end
        end
    end

    assign w_sel_tag = r_tags[int'(w_sel_way)*TAG_BITS +: TAG_BITS];

    // Next-state, walk index and one-cycle strobes; a reset request aborts a flush.
    always_comb begin
        w_state_nxt    = r_state;
        w_walk_nxt     = r_walk_set;
        w_done_nxt     = 1'b0;
        w_rst_pend_nxt = r_rst_pend;
        w_capture      = 1'b0;
        w_load_evict   = 1'b0;
        w_clr_bit      = 1'b0;
        w_latch_fl     = 1'b0;
        rd_set_en      = 1'b0;
        wr_inv_set     = 1'b0;
        wr_inv_way     = 1'b0;
        evict_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_rst) begin
                    w_state_nxt = S_RST_WALK;
                    w_walk_nxt  = '0;
                end else if (start_flush) begin
                    w_state_nxt = S_FL_RD;
                    w_walk_nxt  = '0;
                    w_latch_fl  = 1'b1;
                end
            end
            S_RST_WALK: begin
                // r_go holds off the first invalidate until reset has been released.
                wr_inv_set = r_go;
                if (start_rst) begin
                    w_walk_nxt = '0;
                end else if (r_go) begin
                    w_walk_nxt = r_walk_set + SET_ONE;
                    if (r_walk_set == SET_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            S_FL_RD: begin
                rd_set_en   = 1'b1;
                w_state_nxt = S_FL_LOOKUP;
            end
            S_FL_LOOKUP: begin
                w_capture   = 1'b1;
                w_state_nxt = S_FL_SCAN;
            end
            S_FL_SCAN: begin
                if (w_sel_hit) begin
                    w_load_evict = 1'b1;
                    w_state_nxt  = S_FL_EVICT;
                end else begin
                    w_state_nxt = S_FL_NEXT;
                end
            end
            S_FL_EVICT: begin
                evict_valid = 1'b1;
                if (evict_ready) begin
                    w_state_nxt = S_FL_INV;
                end else if (start_rst) begin
                    w_rst_pend_nxt = 1'b1;
                end
            end
            S_FL_INV: begin
                wr_inv_way  = 1'b1;
                w_clr_bit   = 1'b1;
                w_state_nxt = S_FL_SCAN;
            end
            S_FL_NEXT: begin
                w_walk_nxt = r_walk_set + SET_ONE;
                if (r_walk_set == SET_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_FL_RD;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Abort: any flush state on a reset request, except FL_EVICT which
        // must first finish its handshake (the request is queued meanwhile).
        if (r_state != S_IDLE && r_state != S_RST_WALK &&
            (start_rst || r_rst_pend) &&
            (r_state != S_FL_EVICT || evict_ready)) begin
            w_state_nxt    = S_RST_WALK;
            w_walk_nxt     = '0;
            w_done_nxt     = 1'b0;
            w_rst_pend_nxt = 1'b0;
            w_capture      = 1'b0;
            w_load_evict   = 1'b0;
            w_clr_bit      = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_RST_WALK;
            r_walk_set <= '0;
            r_done     <= 1'b0;
            r_rst_pend <= 1'b0;
            r_go       <= 1'b0;
            r_fl_all   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_walk_set <= w_walk_nxt;
            r_done     <= w_done_nxt;
            r_rst_pend <= w_rst_pend_nxt;
            r_go       <= 1'b1;
            if (w_latch_fl) r_fl_all <= flush_all;
        end
    end

    // Per-set buffers and the held evict request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask       <= '0;
            r_tags       <= '0;
            r_evict_way  <= '0;
            r_evict_addr <= '0;
        end else begin
            if (w_capture) begin
                r_mask <= w_pend;
                r_tags <= tags_buf;
            end else if (w_clr_bit) begin
                r_mask[r_evict_way] <= 1'b0;
            end
            if (w_load_evict) begin
                r_evict_way  <= w_sel_way;
                r_evict_addr <= {w_sel_tag, r_walk_set};
            end
        end
    end

    assign walk_set    = r_walk_set;
    assign evict_way   = r_evict_way;
    assign evict_addr  = r_evict_addr;
    assign done        = r_done;
    assign rst_stall   = (r_state == S_RST_WALK);
    assign flush_stall = (r_state != S_IDLE) && (r_state != S_RST_WALK);

endmodule

// File: tb/tb_llc_rst_flush_seq.sv
// Bench for llc_rst_flush_seq with 4 sets x 4 ways, 4-bit tags.
// The bench keeps its own tag/state array, answers set reads from it and applies
// the invalidates. Expected per-cycle output traces are built from the walk rules.
module tb_llc_rst_flush_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_rst = 1'b0, start_flush = 1'b0, flush_all = 1'b0;
    logic       evict_ready = 1'b0;
    logic [7:0] states_buf = '0;
    logic [15:0] tags_buf = '0;
    logic       rd_set_en, evict_valid, wr_inv_way, wr_inv_set;
    logic       rst_stall, flush_stall, done;
    logic [1:0] walk_set, evict_way;
    logic [5:0] evict_addr;

    llc_rst_flush_seq #(.SET_BITS(2), .WAYS(4), .WAY_BITS(2), .TAG_BITS(4)) dut (
        .clk(clk), .rst(rst), .start_rst(start_rst), .start_flush(start_flush),
        .flush_all(flush_all), .rd_set_en(rd_set_en), .walk_set(walk_set),
        .states_buf(states_buf), .tags_buf(tags_buf), .evict_valid(evict_valid),
        .evict_ready(evict_ready), .evict_addr(evict_addr), .evict_way(evict_way),
        .wr_inv_way(wr_inv_way), .wr_inv_set(wr_inv_set), .rst_stall(rst_stall),
        .flush_stall(flush_stall), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sig;   // rd_set_en, wr_inv_set, wr_inv_way, evict_valid
        logic [5:0] addr;
        logic [1:0] way;
        logic [1:0] walk;
        logic [2:0] st;    // rst_stall, flush_stall, done
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] hs_q[$];
    logic       arr_v[4][4];
    logic       arr_d[4][4];
    logic [3:0] arr_t[4][4];
    int         g_stall = 0;
    int         n_cmp = 0, n_bad = 0;
    int         rd_cnt, iset_cnt, iway_cnt, ev_cyc, fs_cyc, dn_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        n_cmp++;
        if (act !== ex) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, ex, $time);
        end
    endtask

    function automatic void pushe(input logic [3:0] sig, input logic [5:0] addr,
                                  input logic [1:0] way, input logic [1:0] walk,
                                  input logic [2:0] st);
        exp_t e;
        e.sig = sig; e.addr = addr; e.way = way; e.walk = walk; e.st = st;
        exp_q.push_back(e);
    endfunction

    function automatic void push_idle(input logic dn);
        pushe(4'b0000, 6'h0, 2'd0, 2'd0, {2'b00, dn});
    endfunction

    // Whole-set invalidate of every set in order, then done in the first idle cycle.
    function automatic void push_rst_sweep();
        for (int s = 0; s < 4; s++) pushe(4'b0100, 6'h0, 2'd0, 2'(s), 3'b100);
        push_idle(1'b1);
        push_idle(1'b0);
    endfunction

    // Per set: read, lookup, then scan/evict/invalidate per selected way in
    // ascending order, a final empty scan and the advance step.
    function automatic void gen_flush(input logic fa, input int stall);
        for (int s = 0; s < 4; s++) begin
            pushe(4'b1000, 6'h0, 2'd0, 2'(s), 3'b010);
            pushe(4'b0000, 6'h0, 2'd0, 2'(s), 3'b010);
            for (int w = 0; w < 4; w++) begin
                if (arr_v[s][w] && (arr_d[s][w] || fa)) begin
                    pushe(4'b0000, 6'h0, 2'd0, 2'(s), 3'b010);
                    for (int k = 0; k <= stall; k++)
                        pushe(4'b0001, {arr_t[s][w], 2'(s)}, 2'(w), 2'(s), 3'b010);
                    pushe(4'b0010, 6'h0, 2'd0, 2'(s), 3'b010);
                end
            end
            pushe(4'b0000, 6'h0, 2'd0, 2'(s), 3'b010);
            pushe(4'b0000, 6'h0, 2'd0, 2'(s), 3'b010);
        end
        push_idle(1'b1);
        push_idle(1'b0);
    endfunction

    function automatic void clear_arr();
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 4; w++) begin
                arr_v[s][w] = 1'b0; arr_d[s][w] = 1'b0; arr_t[s][w] = 4'h0;
            end
    endfunction

    task automatic clr_cnt();
        rd_cnt = 0; iset_cnt = 0; iway_cnt = 0; ev_cyc = 0; fs_cyc = 0; dn_cnt = 0;
        hs_q.delete();
    endtask

    task automatic wait_drain(input int max);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Array side: answer reads, apply invalidates, drive evict_ready with g_stall wait cycles.
    initial begin : drv
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (rd_set_en)
                    for (int w = 0; w < 4; w++) begin
                        states_buf[2*w +: 2] = {arr_v[walk_set][w], arr_d[walk_set][w]};
                        tags_buf[4*w +: 4]   = arr_t[walk_set][w];
                    end
                if (wr_inv_set)
                    for (int w = 0; w < 4; w++) begin
                        arr_v[walk_set][w] = 1'b0; arr_d[walk_set][w] = 1'b0;
                    end
                if (wr_inv_way) begin
                    arr_v[walk_set][evict_way] = 1'b0;
                    arr_d[walk_set][evict_way] = 1'b0;
                end
                if (evict_valid) begin
                    evict_ready = (run >= g_stall);
                    if (evict_ready) hs_q.push_back({evict_addr, evict_way});
                    run++;
                end else begin
                    evict_ready = 1'b0;
                    run = 0;
                end
            end
        end
    end

    // Per-cycle compare against the expected trace, plus invariants and counters.
    initial begin : cmp
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                chk("exclusive", {30'b0,
                    ($countones({rd_set_en, wr_inv_set, wr_inv_way}) <= 1),
                    !(rst_stall && flush_stall)}, 32'h3);
                rd_cnt   += int'(rd_set_en);
                iset_cnt += int'(wr_inv_set);
                iway_cnt += int'(wr_inv_way);
                ev_cyc   += int'(evict_valid);
                fs_cyc   += int'(flush_stall);
                dn_cnt   += int'(done);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("trace_ctl",
                    {rd_set_en, wr_inv_set, wr_inv_way, evict_valid,
                     rst_stall, flush_stall, done, walk_set},
                    {e.sig, e.st, e.walk});
                if (e.sig[0]) chk("trace_evict", {evict_addr, evict_way}, {e.addr, e.way});
            end
        end
    end

    task automatic run_flush(input logic fa, input int stall);
        @(negedge clk);
        clr_cnt();
        gen_flush(fa, stall);
        g_stall = stall;
        flush_all = fa;
        start_flush = 1'b1;
        @(negedge clk);
        start_flush = 1'b0;
        wait_drain(400);
        g_stall = 0;
    endtask

    initial begin : main
        clear_arr();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {rd_set_en, wr_inv_set, wr_inv_way, evict_valid,
                            rst_stall, flush_stall, done, walk_set}, {7'b0000100, 2'b00});

        // Automatic reset sweep after release.
        @(negedge clk);
        clr_cnt();
        push_rst_sweep();
        rst = 1'b1;
        wait_drain(50);
        chk("rst_done_cnt", dn_cnt, 1);
        chk("rst_inv_set_cnt", iset_cnt, 4);
        chk("rst_walk_end", walk_set, 0);

        // Clean flush: valid-clean lines only, flush_all=0.
        clear_arr();
        for (int w = 0; w < 4; w++) begin
            arr_v[1][w] = 1'b1; arr_t[1][w] = 4'(w + 2);
        end
        run_flush(1'b0, 0);
        chk("clean_rd_cnt", rd_cnt, 4);
        chk("clean_evict_cyc", ev_cyc, 0);
        chk("clean_flush_stall_cyc", fs_cyc, 16);   // RD, LOOKUP, SCAN, NEXT per set
        chk("clean_done_cnt", dn_cnt, 1);

        // Two dirty lines in set 2.
        clear_arr();
        arr_v[2][0] = 1'b1; arr_t[2][0] = 4'h3;
        arr_v[2][1] = 1'b1; arr_d[2][1] = 1'b1; arr_t[2][1] = 4'h5;
        arr_v[2][3] = 1'b1; arr_d[2][3] = 1'b1; arr_t[2][3] = 4'hA;
        run_flush(1'b0, 0);
        chk("dirty_hs_cnt", hs_q.size(), 2);
        if (hs_q.size() == 2) begin
            chk("dirty_hs0", hs_q[0], {6'h16, 2'd1});
            chk("dirty_hs1", hs_q[1], {6'h2A, 2'd3});
        end
        chk("dirty_inv_way_cnt", iway_cnt, 2);
        chk("dirty_way1_gone", arr_v[2][1], 0);
        chk("clean_way0_kept", arr_v[2][0], 1);

        // flush_all with backpressure: 5 cycles not ready.
        clear_arr();
        arr_v[0][0] = 1'b1; arr_t[0][0] = 4'h7;
        run_flush(1'b1, 5);
        chk("bp_evict_cyc", ev_cyc, 6);
        chk("bp_hs_cnt", hs_q.size(), 1);
        if (hs_q.size() == 1) chk("bp_hs0", hs_q[0], {6'h1C, 2'd0});
        chk("bp_inv_way_cnt", iway_cnt, 1);

        // Reset request while the evict handshake is pending.
        clear_arr();
        arr_v[0][0] = 1'b1; arr_t[0][0] = 4'h7;
        arr_v[3][2] = 1'b1; arr_d[3][2] = 1'b1; arr_t[3][2] = 4'h9;
        @(negedge clk);
        clr_cnt();
        pushe(4'b1000, 6'h0, 2'd0, 2'd0, 3'b010);
        pushe(4'b0000, 6'h0, 2'd0, 2'd0, 3'b010);
        pushe(4'b0000, 6'h0, 2'd0, 2'd0, 3'b010);
        for (int k = 0; k < 5; k++) pushe(4'b0001, 6'h1C, 2'd0, 2'd0, 3'b010);
        push_rst_sweep();
        g_stall = 4;
        flush_all = 1'b1;
        start_flush = 1'b1;
        @(negedge clk);
        start_flush = 1'b0;
        repeat (4) @(negedge clk);
        start_rst = 1'b1;
        @(negedge clk);
        start_rst = 1'b0;
        wait_drain(100);
        g_stall = 0;
        chk("abort_done_cnt", dn_cnt, 1);
        chk("abort_flush_stall_cyc", fs_cyc, 8);
        chk("abort_inv_way_cnt", iway_cnt, 0);
        chk("abort_hs_cnt", hs_q.size(), 1);
        chk("abort_sweep_cleared", arr_v[3][2], 0);

        // start_rst and start_flush together: reset only.
        @(negedge clk);
        clr_cnt();
        push_rst_sweep();
        repeat (3) push_idle(1'b0);
        start_rst = 1'b1;
        start_flush = 1'b1;
        @(negedge clk);
        start_rst = 1'b0;
        start_flush = 1'b0;
        wait_drain(50);
        chk("both_flush_stall_cyc", fs_cyc, 0);
        chk("both_rd_cnt", rd_cnt, 0);
        chk("both_done_cnt", dn_cnt, 1);

        // start_rst during the reset sweep restarts it at set 0.
        @(negedge clk);
        clr_cnt();
        pushe(4'b0100, 6'h0, 2'd0, 2'd0, 3'b100);
        pushe(4'b0100, 6'h0, 2'd0, 2'd1, 3'b100);
        push_rst_sweep();
        start_rst = 1'b1;
        @(negedge clk);
        start_rst = 1'b0;
        @(negedge clk);
        start_rst = 1'b1;
        @(negedge clk);
        start_rst = 1'b0;
        wait_drain(50);
        chk("restart_inv_set_cnt", iset_cnt, 6);
        chk("restart_done_cnt", dn_cnt, 1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
